// File: rtl/m_shift_unit_if.sv
// rtl/m_shift_unit_if.sv - request/result handshake bundle for m_shift_unit
interface m_shift_unit_if #(
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_operand;
    logic [2:0]       in_kind;
    logic [AW-1:0]    in_amount;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_carry;
    logic             out_illegal;

    modport master (
        output in_valid, in_operand, in_kind, in_amount, out_ready,
        input  in_ready, out_valid, out_result, out_carry, out_illegal
    );

    modport slave (
        input  in_valid, in_operand, in_kind, in_amount, out_ready,
        output in_ready, out_valid, out_result, out_carry, out_illegal
    );
endinterface

// File: rtl/m_shift_unit.sv
// rtl/m_shift_unit.sv - iterative shift/rotate execution unit, STEP bit positions per cycle
module m_shift_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int AW    = $clog2(WIDTH)
) (
    input logic           clk,
    input logic           rst,
    input logic           flush,
    m_shift_unit_if.slave bus
);
    localparam logic [2:0]  k_shl  = 3'd0;
    localparam logic [2:0]  k_shr  = 3'd1;
    localparam logic [2:0]  k_asr  = 3'd2;
    localparam logic [2:0]  k_rol  = 3'd3;
    localparam logic [2:0]  k_ror  = 3'd4;
    localparam logic [AW:0] step_c = (AW+1)'(STEP);

    typedef enum logic [1:0] {
        st_idle,
        st_shift,
        st_done
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] work_q;
    logic [2:0]       kind_q;
    logic [AW:0]      rem_q;
    logic             carry_q;
    logic             illegal_q;

    logic             ready_c;
    logic             accept;
    logic [AW:0]      step_amt;
    logic [WIDTH:0]   shl_ext;
    logic [WIDTH:0]   shr_ext;
    logic [WIDTH:0]   asr_ext;
    logic [2*WIDTH-1:0] rol_dbl;
    logic [2*WIDTH-1:0] ror_dbl;
    logic [WIDTH-1:0] shift_res;
    logic             shift_carry;

    assign ready_c = (state_q == st_idle) || ((state_q == st_done) && bus.out_ready);
    assign accept  = bus.in_valid && ready_c && !flush;

    // The guard bit beside the operand catches the last bit shifted out,
    // and the doubled operand turns a rotate into a plain shift.
    always_comb begin
        step_amt    = (rem_q > step_c) ? step_c : rem_q;
        shl_ext     = {1'b0, work_q} << step_amt;
        shr_ext     = {work_q, 1'b0} >> step_amt;
        asr_ext     = $signed({work_q, 1'b0}) >>> step_amt;
        rol_dbl     = {work_q, work_q} << step_amt;
        ror_dbl     = {work_q, work_q} >> step_amt;
        shift_res   = work_q;
        shift_carry = carry_q;
        case (kind_q)
            k_shl: begin
                shift_res   = shl_ext[WIDTH-1:0];
                shift_carry = shl_ext[WIDTH];
            end
            k_shr: begin
                shift_res   = shr_ext[WIDTH:1];
                shift_carry = shr_ext[0];
            end
            k_asr: begin
                shift_res   = asr_ext[WIDTH:1];
                shift_carry = asr_ext[0];
            end
            k_rol: begin
                shift_res   = rol_dbl[2*WIDTH-1:WIDTH];
                shift_carry = rol_dbl[WIDTH];
            end
            k_ror: begin
                shift_res   = ror_dbl[WIDTH-1:0];
                shift_carry = ror_dbl[WIDTH-1];
            end
            default: begin
                shift_res   = work_q;
                shift_carry = carry_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= st_idle;
            work_q    <= '0;
            kind_q    <= k_shl;
            rem_q     <= '0;
            carry_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else if (flush) begin
            state_q <= st_idle;
        end else begin
            case (state_q)
                st_shift: begin
                    work_q  <= shift_res;
                    carry_q <= shift_carry;
                    rem_q   <= rem_q - step_amt;
                    if (rem_q == step_amt) begin
                        state_q <= st_done;
                    end
                end
                st_done: begin
                    if (bus.out_ready) begin
                        state_q <= st_idle;
                    end
                end
                default: begin
                    state_q <= st_idle;
                end
            endcase
            // Acceptance overrides the DONE->IDLE step so results go back to back.
            if (accept) begin
                work_q    <= bus.in_operand;
                kind_q    <= bus.in_kind;
                rem_q     <= {1'b0, bus.in_amount};
                carry_q   <= 1'b0;
                illegal_q <= (bus.in_kind > k_ror);
                if ((bus.in_kind > k_ror) || (bus.in_amount == '0)) begin
                    state_q <= st_done;
                end else begin
                    state_q <= st_shift;
                end
            end
        end
    end

    assign bus.in_ready    = ready_c;
    assign bus.out_valid   = (state_q == st_done);
    assign bus.out_result  = work_q;
    assign bus.out_carry   = carry_q;
    assign bus.out_illegal = illegal_q;
endmodule
